life_sequencer: RTL

- Parametrised successor to the Game-of-Life array phase controller.
- Drives the per-cell phase strobes (write_array / run / write_mem) and the position index across 2^POS_BITS positions.
- Gates simulation steps into whole, sweep-aligned generations.
- Adds a runtime-loadable delay, free-run / pause / single-step modes and a generation counter.

---
 rtl/life_sequencer.sv | 74 +++++++
 1 files changed

// File: rtl/life_sequencer.sv
// life_sequencer: Game-of-Life phase/position sequencer; gates sweeps into generations with delay, free-run/pause/step modes and a generation counter
module life_sequencer #(
  parameter int          POS_BITS    = 2,
  parameter logic [31:0] DELAY       = 32'd99999999,
  parameter int          GEN_W       = 16,
  parameter bit          GATE_WRITES = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic                step,
  input  logic                delay_load,
  input  logic [31:0]         delay_value,
  output logic                write_array,
  output logic                run,
  output logic                write_mem,
  output logic [POS_BITS-1:0] pos,
  output logic                sweep_active,
  output logic                gen_done,
  output logic [GEN_W-1:0]    gen_count
);
  localparam int CW = POS_BITS + 2;
  typedef enum logic [1:0] {IDLE, ARMED, SWEEP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0] timer, timer_n, delay_reg;
  logic gen_done_n, at_max, wgate;
  assign at_max = &cnt;
  always_comb begin
    state_n = state;
    timer_n = timer;
    gen_done_n = 1'b0;
    case (state)
      SWEEP: begin
        state_n = at_max ? IDLE : SWEEP;
        gen_done_n = at_max;
      end
      ARMED: state_n = mode[0] ? IDLE : (at_max ? SWEEP : ARMED);
      default: begin
        if (mode == 2'b00) begin
          state_n = (timer == delay_reg) ? ARMED : IDLE;
          timer_n = timer + 32'd1;
        end else if (mode == 2'b10 && step) begin
          state_n = ARMED;
        end
      end
    endcase
    if (delay_load && state == IDLE && mode == 2'b00) state_n = IDLE;
    if (delay_load || state_n != IDLE) timer_n = '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      timer <= '0;
      delay_reg <= DELAY;
      gen_done <= 1'b0;
      gen_count <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt + 1'b1;
      timer <= timer_n;
      delay_reg <= delay_load ? delay_value : delay_reg;
      gen_done <= gen_done_n;
      gen_count <= gen_count + GEN_W'(gen_done_n);
    end
  end
  assign sweep_active = state == SWEEP;
  assign wgate = GATE_WRITES ? sweep_active : 1'b1;
  assign pos = cnt[CW-1:2];
  assign write_array = cnt[1:0] == 2'b01 && wgate;
  assign write_mem = cnt[1:0] == 2'b11 && wgate;
  assign run = cnt[1:0] == 2'b10 && sweep_active;
endmodule
